// File: rtl/instr_queue.sv
// Fetch-to-decode instruction FIFO; head entry feeds the decoder directly.
// Optional same-cycle bypass when empty: define INSTR_QUEUE_BYPASS_EN.

package tortoise_pkg;

    localparam logic [31:0] ILLEGAL_INSTR = 32'd2;

    typedef struct packed {
        logic [31:0] cause;
        logic [31:0] tval;
        logic        valid;
    } exception_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] predict_address;
    } branchpredict_t;

    typedef struct packed {
        logic [31:0]    addr;
        logic [31:0]    instr;
        branchpredict_t predict;
        exception_t     ex;
        logic           valid;
    } fetch_entry_t;

endpackage

module instr_queue
    import tortoise_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_valid_i,
    input  fetch_entry_t     fetch_entry_i,
    output logic             push_ready_o,
    output fetch_entry_t     fetch_entry_o,
    output logic             pop_valid_o,
    input  logic             pop_ack_i,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;

    logic full;
    logic empty;
    logic byp;
    logic push;
    logic pop;
    logic wr_en;
    logic rd_en;

    assign full  = (cnt == CNT_W'(DEPTH));
    assign empty = (cnt == '0);

    // Ready depends only on state and flush, never on pop_ack_i.
    assign push_ready_o = rst_ni & ~full & ~flush_i;

`ifdef INSTR_QUEUE_BYPASS_EN
    assign byp = empty & push_valid_i & push_ready_o;
`else
    assign byp = 1'b0;
`endif

    assign pop_valid_o = (~empty & ~flush_i) | byp;

    assign push = push_valid_i & push_ready_o;
    assign pop  = pop_valid_o & pop_ack_i;

    // A bypassed entry consumed in the same cycle never touches storage.
    assign wr_en = push & ~(byp & pop_ack_i);
    assign rd_en = pop & ~byp;

    always_comb begin
        fetch_entry_o       = byp ? fetch_entry_i : mem[rd_ptr];
        fetch_entry_o.valid = pop_valid_o;
    end

    assign count_o = cnt;

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_ptr] <= fetch_entry_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            cnt <= cnt + CNT_W'(wr_en) - CNT_W'(rd_en);
        end
    end

`ifndef SYNTHESIS
    a_push_stable : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (push_valid_i && !push_ready_o && !flush_i) |=> (push_valid_i && $stable(fetch_entry_i))
    );

    a_cnt_range : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        cnt <= CNT_W'(DEPTH)
    );
`endif

endmodule

// File: doc/instr_queue.md
Name: instr_queue

Overview:
- FIFO between the frontend fetch stage and the decoder; buffers tortoise_pkg::fetch_entry_t words (instr, addr, predict, ex) so fetch and decode/issue stalls decouple.
- Head entry drives the decoder's fetch input directly.
- Pops when issue accepts the decoded scoreboard entry.
- Flushed on branch mispredict or exception redirect.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- CNT_W, $clog2(DEPTH)+1, occupancy counter width; derived, not overridden.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  synchronous flush; discards all entries.
- push_valid_i  in  1  frontend offers fetch_entry_i.
- fetch_entry_i  in  $bits(fetch_entry_t)  entry from fetch.
- push_ready_o  out  1  queue can accept this cycle.
- fetch_entry_o  out  $bits(fetch_entry_t)  head entry to decoder; .valid field equals pop_valid_o.
- pop_valid_o  out  1  head entry valid.
- pop_ack_i  in  1  issue consumed head this cycle; ignored when pop_valid_o=0.
- count_o  out  CNT_W  current occupancy.

Behaviour:
- Storage: DEPTH-entry array.
- Pointers: wr_ptr and rd_ptr, log2(DEPTH) bits, wrap modulo DEPTH.
- Occupancy: cnt is CNT_W bits, range 0..DEPTH.
- Reset (rst_ni=0, async): wr_ptr=rd_ptr=0; cnt=0; pop_valid_o=0; count_o=0; push_ready_o=0 while reset is asserted, 1 from first cycle after release. Array contents are not reset.
- push_ready_o = (cnt != DEPTH) & ~flush_i.
- pop_valid_o = (cnt != 0) & ~flush_i.
- push = push_valid_i & push_ready_o; pop = pop_valid_o & pop_ack_i.
- Push: writes array[wr_ptr], wr_ptr++ at edge.
- Pop: rd_ptr++ at edge.
- Counter: cnt += push - pop. Simultaneous push+pop leaves cnt unchanged. Legal at any non-full, non-empty occupancy.
- Full (cnt=DEPTH): push_ready_o=0 even if pop_ack_i=1 the same cycle. No combinational ready-from-ack path.
- Empty (cnt=0): pop_valid_o=0; fetch_entry_o content don't-care except .valid=0. Push-to-pop latency is 1 cycle.
- Flush: at the edge with flush_i=1, wr_ptr=rd_ptr=0 and cnt=0; any push or pop in that cycle is dropped. Flush has priority over all other events.
- Ordering: strict FIFO. The entry's ex field passes through unmodified; an exception entry does not block later pushes.
- count_o = cnt (registered).
- Reset asserted mid-operation: all state clears immediately; no entry is emitted after release until a new push.
- Assertions: push_valid_i must hold fetch_entry_i stable until push_ready_o; cnt never exceeds DEPTH.

Optional Feature:
- Macro INSTR_QUEUE_BYPASS_EN.
- Defined:
  - When cnt=0 and push_valid_i=1 (no flush), pop_valid_o=1 and fetch_entry_o=fetch_entry_i combinationally, so latency is 0.
  - If pop_ack_i=1 that cycle, the entry is not written and pointers and cnt are unchanged.
  - Otherwise it is written normally.
- Not defined: no bypass path; minimum latency is 1 cycle, as above.

Test Plan:
- Reset then push addr 0x8000_0000 instr 0x00000013 (cycle 0), no ack -> cycle 1: pop_valid_o=1, fetch_entry_o.addr=0x8000_0000, count_o=1. With BYPASS_EN: pop_valid_o=1 in cycle 0.
- Push 4 entries (addr 0x100,0x104,0x108,0x10C) with no ack -> count_o=4, push_ready_o=0. A 5th push is held (not lost) and is accepted the cycle after the first ack. Output order is 0x100,0x104,0x108,0x10C,0x110.
- Steady push+ack every cycle for 20 cycles at count 2 -> count_o stays 2; addresses emerge in order across pointer wrap.
- Count 3, flush_i=1 together with push_valid_i=1 and pop_ack_i=1 -> next cycle count_o=0, pop_valid_o=0, pushed entry absent. The following push is emitted after 1 cycle.
- Push entry with ex.valid=1, cause ILLEGAL_INSTR, then a normal entry -> both emerge in order with ex fields bit-identical to the inputs.
- Assert rst_ni=0 asynchronously mid-cycle at count 3 -> pop_valid_o and count_o drop to 0 before the next edge; after release, push_ready_o=1 and the queue is empty.
